// File: rtl/ecc_pkg.sv
// Shared Hamming(16,11) definitions: encoder FSM states, message/codeword widths
// and parity bit positions. The correction decoder imports the same package.
`timescale 1ns/1ps
package ecc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    WR_LO,
    WR_HI,
    DONE
  } enc_state_t;

  localparam int MSG_W  = 11;
  localparam int CODE_W = 16;

  localparam int P1 = 1;
  localparam int P2 = 2;
  localparam int P4 = 4;
  localparam int P8 = 8;

endpackage

// File: rtl/hamming_enc_core.sv
// Combinational Hamming(16,11) encoder, d[10:0] -> c[15:0].
// Define HAMMING_P0_EN to add the overall parity bit c[0] (SECDED); otherwise c[0]=0.
`timescale 1ns/1ps
module hamming_enc_core
  import ecc_pkg::*;
(
  input  logic [MSG_W-1:0]  d,
  output logic [CODE_W-1:0] c
);

  logic [CODE_W-1:0] placed;
  logic              p8;
  logic              p4;
  logic              p2;
  logic              p1;

  // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
  always_comb begin
    placed        = '0;
    placed[15:9]  = d[10:4];
    placed[7:5]   = d[3:1];
    placed[3]     = d[0];

    p8 = ^placed[15:9];
    p4 = ^{placed[15:12], placed[7:5]};
    p2 = ^{placed[15:14], placed[11:10], placed[7:6], placed[3]};
    p1 = ^{placed[15], placed[13], placed[11], placed[9], placed[7], placed[5], placed[3]};

    c     = placed;
    c[P8] = p8;
    c[P4] = p4;
    c[P2] = p2;
    c[P1] = p1;
`ifdef HAMMING_P0_EN
    // Overall parity over all other bits gives double-error detection.
    c[0]  = ^{placed, p8, p4, p2, p1};
`else
    c[0]  = 1'b0;
`endif
  end

endmodule

// File: rtl/hamming_enc_engine.sv
// Memory-walking Hamming(16,11) encoder: reads 2-byte messages, writes 2-byte codewords.
// Overall parity bit c[0] is generated only when HAMMING_P0_EN is defined.
`timescale 1ns/1ps
module hamming_enc_engine
  import ecc_pkg::*;
#(
  parameter int AW        = 8,
  parameter int SRC_BASE  = 0,
  parameter int DST_BASE  = 30,
  parameter int NUM_WORDS = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata
);

  localparam int IDX_W = 7;

  localparam logic [AW-1:0]    SRC  = AW'(SRC_BASE);
  localparam logic [AW-1:0]    DST  = AW'(DST_BASE);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_WORDS - 1);

  enc_state_t          state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [7:0]          d_lo_q, d_lo_d;
  logic [CODE_W-1:0]   code_q, code_d;

  logic [CODE_W-1:0]   enc_c;
  logic [AW-1:0]       byte_off;
  logic                unused_rdata_hi;

  // Only the low three bits of the high message byte carry data.
  assign unused_rdata_hi = ^mem_rdata[7:3];

  hamming_enc_core u_core (
    .d ({mem_rdata[2:0], d_lo_q}),
    .c (enc_c)
  );

  // Address arithmetic wraps modulo 2^AW without any flag.
  assign byte_off = AW'({idx_q, 1'b0});

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      d_lo_q  <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      d_lo_q  <= d_lo_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    d_lo_d  = d_lo_q;
    code_d  = code_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = '0;
          state_d = RD_LO;
        end
      end
      RD_LO: begin
        d_lo_d  = mem_rdata;
        state_d = RD_HI;
      end
      RD_HI: begin
        code_d  = enc_c;
        state_d = WR_LO;
      end
      WR_LO: state_d = WR_HI;
      WR_HI: begin
        idx_d   = idx_q + 1'b1;
        state_d = (idx_q == LAST) ? DONE : RD_LO;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    done      = 1'b0;
    mem_addr  = '0;
    mem_wr_en = 1'b0;
    mem_wdata = '0;
    unique case (state_q)
      RD_LO: mem_addr = SRC + byte_off;
      RD_HI: mem_addr = SRC + byte_off + 1'b1;
      WR_LO: begin
        mem_addr  = DST + byte_off;
        mem_wr_en = 1'b1;
        mem_wdata = code_q[7:0];
      end
      WR_HI: begin
        mem_addr  = DST + byte_off + 1'b1;
        mem_wr_en = 1'b1;
        mem_wdata = code_q[15:8];
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hamming_enc_engine.sv
// Scoreboard bench for hamming_enc_engine: expected memory writes are queued at launch
// and a negedge monitor pops/compares every write strobe the DUT presents.
`timescale 1ns/1ps
module tb_hamming_enc_engine;

  localparam int AW  = 8;
  localparam int NW  = 15;
  localparam int DST = 30;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          busy;
  logic          done;
  logic [AW-1:0] mem_addr;
  logic          mem_wr_en;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;

  logic [7:0]    mem [0:255];
  logic          ld_en;
  logic [7:0]    ld_addr;
  logic [7:0]    ld_data;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t  sb_q[$];
  wr_t  mon_e;
  int   total = 0;
  int   bad   = 0;

  logic [7:0]  src_lo   [NW];
  logic [7:0]  src_hi   [NW];
  logic [15:0] exp_code [NW];

`ifdef HAMMING_P0_EN
  localparam logic [15:0] H_ONES = 16'hFFFF;
  localparam logic [15:0] H_BIT0 = 16'h000F;
  localparam logic [15:0] H_BIT10 = 16'h8117;
`else
  localparam logic [15:0] H_ONES = 16'hFFFE;
  localparam logic [15:0] H_BIT0 = 16'h000E;
  localparam logic [15:0] H_BIT10 = 16'h8116;
`endif

  hamming_enc_engine #(
    .AW        (AW),
    .SRC_BASE  (0),
    .DST_BASE  (DST),
    .NUM_WORDS (NW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_wr_en (mem_wr_en),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    else if (ld_en) mem[ld_addr] <= ld_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Positional Hamming reference: data fills non-power-of-two positions in ascending order,
  // each parity bit p covers every position j with (j & p) != 0.
  function automatic logic [15:0] ref_enc(input logic [10:0] d);
    logic [15:0] c;
    int k;
    c = '0;
    k = 0;
    for (int j = 1; j < 16; j++) begin
      if (j != 1 && j != 2 && j != 4 && j != 8) begin
        c[j] = d[k];
        k++;
      end
    end
    for (int p = 1; p < 16; p = p * 2) begin
      for (int j = 1; j < 16; j++) begin
        if (((j & p) != 0) && (j != p)) c[p] = c[p] ^ c[j];
      end
    end
`ifdef HAMMING_P0_EN
    c[0] = ^c[15:1];
`endif
    return c;
  endfunction

  always @(negedge clk) begin
    if (mem_wr_en === 1'b1) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: addr=%0h data=%0h expected no write", mem_addr, mem_wdata);
      end else begin
        mon_e = sb_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(mon_e.addr));
        check("wr_data", 32'(mem_wdata), 32'(mon_e.data));
      end
    end
  end

  task automatic load_byte(input logic [7:0] a, input logic [7:0] v);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = v;
    @(negedge clk);
    ld_en   = 1'b0;
  endtask

  task automatic load_mem();
    for (int i = 0; i < NW; i++) begin
      load_byte(8'(2 * i), src_lo[i]);
      load_byte(8'(2 * i + 1), src_hi[i]);
    end
    for (int a = DST; a < 64; a++) load_byte(8'(a), 8'hAA);
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) begin
      sb_q.push_back({8'(DST + 2 * i), exp_code[i][7:0]});
      sb_q.push_back({8'(DST + 2 * i + 1), exp_code[i][15:8]});
    end
  endtask

  // Leaves the bench at the negedge of cycle 1, start seen at edge 0.
  task automatic launch();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_full(input bit pulses);
    launch();
    for (int c = 1; c <= 64; c++) begin
      check($sformatf("busy_c%0d", c), 32'(busy), 32'(c <= 4 * NW + 1));
      check($sformatf("done_c%0d", c), 32'(done), 32'(c == 4 * NW + 1));
      start = pulses && (c == 3 || c == 20);
      @(negedge clk);
    end
    start = 1'b0;
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    for (int a = 60; a < 64; a++) check($sformatf("untouched_%0d", a), 32'(mem[a]), 32'hAA);
    check("src_byte29", 32'(mem[29]), 32'(src_hi[NW-1]));
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    ld_en = 1'b0;
    ld_addr = '0;
    ld_data = '0;

    src_lo = '{8'h00, 8'hFF, 8'h01, 8'h00, 8'h55, 8'hAA, 8'h3C, 8'hC3,
               8'h0F, 8'hF0, 8'h12, 8'hED, 8'h80, 8'h7E, 8'h99};
    src_hi = '{8'h00, 8'h07, 8'hF8, 8'h04, 8'h02, 8'hFD, 8'h01, 8'h06,
               8'hF3, 8'h03, 8'h05, 8'h00, 8'h0A, 8'h07, 8'hE4};
    exp_code[0] = 16'h0000;
    exp_code[1] = H_ONES;
    exp_code[2] = H_BIT0;
    exp_code[3] = H_BIT10;
    for (int i = 4; i < NW; i++) exp_code[i] = ref_enc({src_hi[i][2:0], src_lo[i]});

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wr_en", 32'(mem_wr_en), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // Full run with stray start pulses mid-run.
    load_mem();
    push_words(NW);
    run_full(1'b1);

    // Reset during word 2: only words 0 and 1 reach memory.
    load_mem();
    push_words(2);
    launch();
    for (int c = 1; c <= 10; c++) begin
      check($sformatf("rbusy_c%0d", c), 32'(busy), 32'd1);
      if (c == 10) reset = 1'b1;
      @(negedge clk);
    end
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_wr_en", 32'(mem_wr_en), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_sb_empty", 32'(sb_q.size()), 32'd0);
    check("rst_b30", 32'(mem[30]), 32'(exp_code[0][7:0]));
    check("rst_b31", 32'(mem[31]), 32'(exp_code[0][15:8]));
    check("rst_b32", 32'(mem[32]), 32'(exp_code[1][7:0]));
    check("rst_b33", 32'(mem[33]), 32'(exp_code[1][15:8]));
    for (int a = 34; a < 60; a++) check($sformatf("rst_untouched_%0d", a), 32'(mem[a]), 32'hAA);

    // Fresh start after reset runs from idx 0.
    push_words(NW);
    run_full(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
